fme_search_sequencer: RTL
=========================

// Module: fme_search_sequencer
// PURPOSE
//  Sequences the FME search datapath over two refinement passes per 8x8 block: half-pel around
//  the IME integer vector, then quarter-pel around the winning half-pel point. Drives row fetch
//  and search enable, captures address_best_sad/best_sad per pass, and returns the final
//  quarter-pel MV and SAD with a start/done handshake. Sits between the block-level ME
//  controller and the search instance.
// PARAMETERS
//  DATAWIDTH  8   pixel width; SAD width is DATAWIDTH+9
//  ROWS       8   rows streamed into search per pass
//  LATENCY    6   cycles from the last fed row to a valid best_sad/address_best_sad
//  MV_W       8   signed width of the IME integer MV components
// PORTS
//  clock            in   1             system clock, rising edge
//  reset            in   1             asynchronous, active-low reset
//  start            in   1             request refinement of one block (sampled only in IDLE)
//  ime_mv_x         in   MV_W          signed integer-pel MV x from IME
//  ime_mv_y         in   MV_W          signed integer-pel MV y from IME
//  best_sad_ime     in   DATAWIDTH+9   IME best SAD (integer-pel cost)
//  address_best_sad in   6             search winner index (0..8 = 3x3 grid, row-major)
//  best_sad         in   DATAWIDTH+9   search winner SAD
//  search_enable    out  1             enable to the search block
//  row_valid        out  1             row_idx valid; reference/original buffers read this cycle
//  row_idx          out  3             row being fed, 0..ROWS-1
//  pass             out  1             0 = half-pel pass, 1 = quarter-pel pass
//  center_x         out  MV_W+2        signed quarter-pel centre of current pass (to interpolators)
//  center_y         out  MV_W+2        signed quarter-pel centre of current pass
//  busy             out  1             high from start acceptance until done
//  done             out  1             one-cycle pulse; result outputs valid
//  mv_x             out  MV_W+2        signed final MV x, quarter-pel units
//  mv_y             out  MV_W+2        signed final MV y, quarter-pel units
//  sad              out  DATAWIDTH+9   final best SAD
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0; internal best/centre registers 0.
//  States: IDLE -> H_FEED -> H_WAIT -> H_CAP -> Q_FEED -> Q_WAIT -> Q_CAP -> DONE -> IDLE.
//  IDLE: start=1 latches ime_mv, best_sad_ime; centre = ime_mv*4 (sign-extended, <<2); busy=1.
//  *_FEED: ROWS cycles, row_valid=1, row_idx 0..ROWS-1, search_enable=1.
//  *_WAIT: LATENCY cycles, search_enable=1, row_valid=0, row_idx held at ROWS-1.
//  *_CAP: one cycle, search_enable=0 (forces search to restart next pass); samples
//   address_best_sad and best_sad.
//  Index map: dx = idx%3 - 1, dy = idx/3 - 1; idx > 8 is treated as 4 (centre, offset 0).
//  H_CAP: if best_sad < best_sad_ime (strict), centre += 2*(dx,dy) and best = best_sad;
//   else centre unchanged, best = best_sad_ime. Ties keep integer position.
//  Q_CAP: if best_sad < best (strict), centre += (dx,dy), best = best_sad; else unchanged.
//  DONE: mv_x/mv_y = centre, sad = best, done=1 for one cycle, busy drops in the same
//   cycle; mv/sad hold until the next DONE.
//  Latency start -> done = 2*(ROWS+LATENCY+1)+2 cycles (32 with defaults).
//  pass=0 in H_* states, 1 in Q_* and DONE; center_x/y update the cycle after *_CAP.
//  start while busy: ignored, no queuing. start in the DONE cycle is ignored; accepted from
//   the next IDLE cycle.
//  Arithmetic: centre is two's complement MV_W+2; no saturation (IME range guarantees fit).
//  Reset asserted mid-pass: immediate return to IDLE, done never pulses, search_enable=0.
// TESTING
//  1. start, mv=(3,-2), sad_ime=500; half idx=4 sad=600; quarter idx=4 sad=700
//     -> done at cycle 32, mv=(12,-8), sad=500.
//  2. mv=(0,0), sad_ime=500; half idx=2 sad=400; quarter idx=6 sad=350
//     -> centre (2,-2) after pass 0, final mv=(1,-1), sad=350.
//  3. Ties: half sad=500 (=sad_ime), idx=0 -> centre unchanged, sad=500; idx=12 -> centre.
//  4. start pulsed at cycles 5 and 31 during busy -> ignored; one done only; new start
//     at IDLE accepted.
//  5. Reset low during Q_WAIT -> outputs 0 asynchronously, no done; subsequent start
//     completes normally.
//  6. Check row_idx sequence 0..7 with row_valid, search_enable low exactly in *_CAP/IDLE/DONE.

Source files
------------

// File: rtl/fme_search_sequencer.sv
// fme_search_sequencer: runs half-pel then quarter-pel refinement passes of the FME search
// around the IME vector and returns the final quarter-pel MV and SAD.
module fme_search_sequencer #(
    parameter int DATAWIDTH = 8,
    parameter int ROWS      = 8,
    parameter int LATENCY   = 6,
    parameter int MV_W      = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [MV_W-1:0]      ime_mv_x,
    input  logic signed [MV_W-1:0]      ime_mv_y,
    input  logic [DATAWIDTH+8:0]        best_sad_ime,
    input  logic [5:0]                  address_best_sad,
    input  logic [DATAWIDTH+8:0]        best_sad,
    output logic                        search_enable,
    output logic                        row_valid,
    output logic [2:0]                  row_idx,
    output logic                        pass,
    output logic signed [MV_W+1:0]      center_x,
    output logic signed [MV_W+1:0]      center_y,
    output logic                        busy,
    output logic                        done,
    output logic signed [MV_W+1:0]      mv_x,
    output logic signed [MV_W+1:0]      mv_y,
    output logic [DATAWIDTH+8:0]        sad
);
    localparam int SW = DATAWIDTH + 9;
    localparam int CW = MV_W + 2;
    localparam int NW = $clog2(ROWS > LATENCY ? ROWS : LATENCY) + 1;

    typedef enum logic [2:0] {IDLE, H_FEED, H_WAIT, H_CAP, Q_FEED, Q_WAIT, Q_CAP, DONE} state_t;

    state_t               state_q, state_d;
    logic [NW-1:0]        cnt_q, cnt_d;
    logic signed [CW-1:0] cx_q, cx_d, cy_q, cy_d, mvx_q, mvx_d, mvy_q, mvy_d;
    logic [SW-1:0]        best_q, best_d, sad_q, sad_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [3:0]           idx;
    logic [1:0]           col, row;
    logic signed [CW-1:0] dx, dy, step_x, step_y;
    logic                 is_feed, is_wait, win;

    // Out-of-grid winner indices fall back to the centre point (zero offset).
    always_comb begin
        idx     = address_best_sad > 6'd8 ? 4'd4 : address_best_sad[3:0];
        col     = idx inside {4'd0, 4'd3, 4'd6} ? 2'd0 : idx inside {4'd1, 4'd4, 4'd7} ? 2'd1 : 2'd2;
        row     = idx < 4'd3 ? 2'd0 : idx < 4'd6 ? 2'd1 : 2'd2;
        dx      = col == 2'd0 ? '1 : col == 2'd2 ? CW'(1) : '0;
        dy      = row == 2'd0 ? '1 : row == 2'd2 ? CW'(1) : '0;
        step_x  = state_q == Q_CAP ? dx : dx <<< 1;
        step_y  = state_q == Q_CAP ? dy : dy <<< 1;
        win     = best_sad < best_q;
        is_feed = state_q == H_FEED || state_q == Q_FEED;
        is_wait = state_q == H_WAIT || state_q == Q_WAIT;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        best_d  = best_q;
        mvx_d   = mvx_q;
        mvy_d   = mvy_q;
        sad_d   = sad_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = H_FEED;
                cnt_d   = '0;
                cx_d    = {ime_mv_x, 2'b00};
                cy_d    = {ime_mv_y, 2'b00};
                best_d  = best_sad_ime;
                busy_d  = 1'b1;
            end
            H_FEED, Q_FEED: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == NW'(ROWS - 1)) begin
                    cnt_d   = '0;
                    state_d = state_q == H_FEED ? H_WAIT : Q_WAIT;
                end
            end
            H_WAIT, Q_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == NW'(LATENCY - 1)) begin
                    cnt_d   = '0;
                    state_d = state_q == H_WAIT ? H_CAP : Q_CAP;
                end
            end
            H_CAP, Q_CAP: begin
                if (win) begin
                    cx_d   = cx_q + step_x;
                    cy_d   = cy_q + step_y;
                    best_d = best_sad;
                end
                state_d = state_q == H_CAP ? Q_FEED : DONE;
            end
            DONE: begin
                mvx_d   = cx_q;
                mvy_d   = cy_q;
                sad_d   = best_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            best_q  <= '0;
            mvx_q   <= '0;
            mvy_q   <= '0;
            sad_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            best_q  <= best_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
            sad_q   <= sad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign search_enable = is_feed || is_wait;
    assign row_valid     = is_feed;
    assign row_idx       = is_feed ? 3'(cnt_q) : is_wait ? 3'(ROWS - 1) : 3'd0;
    assign pass          = state_q inside {Q_FEED, Q_WAIT, Q_CAP, DONE};
    assign center_x      = cx_q;
    assign center_y      = cy_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign mv_x          = mvx_q;
    assign mv_y          = mvy_q;
    assign sad           = sad_q;
endmodule
